mem_tile_resp: RTL and testbench

- Memory-side responder for the 128-bit tile / 32-bit DWORD memory protocol that the data and instruction cache tiles initiate on their mem* ports.
- Backs the protocol with on-chip block RAM and serves uncached, tile (op 1) and DWORD (op 2) loads and stores.
- Returns READY / HOLD / OK / FAULT on the 2-bit status.
- Used as boot/scratch RAM and as the cache-side endpoint in simulation.

---
 rtl/mem_tile_resp_pkg.sv | 51 +++++
 rtl/mem_tile_bank.sv | 41 ++++
 rtl/mem_tile_resp.sv | 150 +++++++++++++++
 tb/tb_mem_tile_resp.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_tile_resp_pkg.sv
// Shared definitions for the tile/DWORD memory responder.
//   Status codes returned on memOutOK, operation codes accepted on memInOp,
//   FSM state encoding and the captured-request payload.
package mem_tile_resp_pkg;

  localparam int unsigned DWORD_W   = 32;
  localparam int unsigned TILE_W    = 128;
  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned BANK_W    = 2;
  localparam int unsigned OP_W      = 5;
  localparam int unsigned STATUS_W  = 2;
  localparam int unsigned CNT_W     = 4;

  localparam logic [STATUS_W-1:0] UMEM_OK_READY = 2'b00;
  localparam logic [STATUS_W-1:0] UMEM_OK_OK    = 2'b01;
  localparam logic [STATUS_W-1:0] UMEM_OK_HOLD  = 2'b10;
  localparam logic [STATUS_W-1:0] UMEM_OK_FAULT = 2'b11;

  localparam logic [OP_W-1:0] UMEM_OP_TILE  = 5'd1;
  localparam logic [OP_W-1:0] UMEM_OP_DWORD = 5'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // Request as held for the duration of a transaction (op reduced to a tile flag).
  typedef struct packed {
    logic [TILE_W-1:0] data;
    logic              tile;
    logic              oe;
    logic              wr;
    logic [BANK_W-1:0] bank;
  } req_t;

  // Status shown while the FSM sits in a given state.
  function automatic logic [STATUS_W-1:0] status_of(input state_t s);
    logic [STATUS_W-1:0] st;
    st = UMEM_OK_READY;
    case (s)
      ST_BUSY:  st = UMEM_OK_HOLD;
      ST_DONE:  st = UMEM_OK_OK;
      ST_FAULT: st = UMEM_OK_FAULT;
      default:  st = UMEM_OK_READY;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mem_tile_bank.sv
// One 32-bit DWORD lane of the tile RAM: single-port, registered read.
//   clk, rst_n : clock, async active-low reset (read register only; RAM is not reset)
//   we, re     : write / read enable for this lane
//   addr       : tile index
//   wdata      : write data
//   rdata      : registered read data, holds until the next read
module mem_tile_bank
  import mem_tile_resp_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DWORD_W-1:0]   wdata,
  output logic [DWORD_W-1:0]   rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DWORD_W-1:0] mem [DEPTH];

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_tile_resp.sv
// Memory-side responder for the 128-bit tile / 32-bit DWORD protocol.
//   clock, reset : rising-edge clock, async active-low reset
//   memInAddr    : request byte address
//   memInData    : store data (DWORD stores use [31:0])
//   memInOE/WR   : load / store request
//   memInOp      : 1 = tile, 2 = DWORD
//   memOutData   : load data (DWORD loads zero-extended), valid with OK
//   memOutOK     : READY / HOLD / OK / FAULT
module mem_tile_resp
  import mem_tile_resp_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LAT       = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         memInAddr,
  input  logic [TILE_W-1:0]   memInData,
  input  logic                memInOE,
  input  logic                memInWR,
  input  logic [OP_W-1:0]     memInOp,
  output logic [TILE_W-1:0]   memOutData,
  output logic [STATUS_W-1:0] memOutOK
);

  localparam int unsigned IDX_LO = 4;
  localparam int unsigned IDX_HI = ADDR_BITS + 3;
  localparam int unsigned TAG_LO = ADDR_BITS + 4;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  req_t                 req_q, req_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic                 out_tile_q;
  logic [BANK_W-1:0]    out_bank_q;

  logic req_in;
  logic op_ok;
  logic in_range;
  logic illegal;
  logic commit;

  logic [NUM_BANKS-1:0][DWORD_W-1:0] bank_q;

  // Byte-within-DWORD bits carry no meaning for either op.
  logic unused_addr_bits;
  assign unused_addr_bits = ^memInAddr[1:0];

  // Request decode and legality.
  assign req_in   = memInOE | memInWR;
  assign op_ok    = (memInOp == UMEM_OP_TILE) || (memInOp == UMEM_OP_DWORD);
  // BASE_ADDR is aligned to the RAM size, so the window test is a tag compare
  // and the tile index is simply the address bits above the byte offset.
  assign in_range = (memInAddr[31:TAG_LO] == BASE_ADDR[31:TAG_LO]);
  assign illegal  = !op_ok || (memInOE && memInWR) || !in_range;

  // Last HOLD cycle: the RAM write / read happens on the edge into DONE.
  assign commit = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (req_in) begin
          if (illegal) begin
            state_d = ST_FAULT;
          end else begin
            state_d    = ST_BUSY;
            cnt_d      = CNT_W'(LAT);
            req_d.data = memInData;
            req_d.tile = (memInOp == UMEM_OP_TILE);
            req_d.oe   = memInOE;
            req_d.wr   = memInWR;
            req_d.bank = memInAddr[3:2];
            idx_d      = memInAddr[IDX_HI:IDX_LO];
          end
        end
      end
      ST_BUSY: begin
        // Inputs are ignored here; a withdrawn request still completes.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, request and status registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      idx_q    <= '0;
      memOutOK <= UMEM_OK_READY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      idx_q    <= idx_d;
      memOutOK <= status_of(state_d);
    end
  end

  // Output shaping for the load being committed; unchanged by stores and faults.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_tile_q <= 1'b1;
      out_bank_q <= '0;
    end else if (commit && req_q.oe) begin
      out_tile_q <= req_q.tile;
      out_bank_q <= req_q.bank;
    end
  end

  // Four DWORD lanes A..D; a tile op touches all, a DWORD op only its lane.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic               sel;
    logic [DWORD_W-1:0] wdata;

    assign sel   = req_q.tile || (req_q.bank == BANK_W'(b));
    assign wdata = req_q.tile ? req_q.data[b*DWORD_W +: DWORD_W] : req_q.data[DWORD_W-1:0];

    mem_tile_bank #(
      .ADDR_BITS (ADDR_BITS)
    ) u_bank (
      .clk   (clock),
      .rst_n (reset),
      .we    (commit && req_q.wr && sel),
      .re    (commit && req_q.oe && sel),
      .addr  (idx_q),
      .wdata (wdata),
      .rdata (bank_q[b])
    );
  end

  // Load data comes straight from the lane read registers, so it holds after OK.
  assign memOutData = out_tile_q ? bank_q
                                 : {{(TILE_W-DWORD_W){1'b0}}, bank_q[out_bank_q]};

endmodule

// File: tb/tb_mem_tile_resp.sv
// Self-checking bench for mem_tile_resp: a timeline model of the main (LAT=2)
// instance checked every cycle, directed literal checks, and two side
// instances (LAT=1, LAT=15) sharing the same inputs for HOLD-length checks.
module tb_mem_tile_resp;
  import mem_tile_resp_pkg::*;

  localparam int unsigned AB        = 10;
  localparam int unsigned LAT_M     = 2;
  localparam longint      RAM_BYTES = 16 * (64'd1 << AB);

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  in_addr = '0;
  logic [127:0] in_data = '0;
  logic         in_oe = 1'b0;
  logic         in_wr = 1'b0;
  logic [4:0]   in_op = 5'd2;

  logic [127:0] d_m, d_1, d_15;
  logic [1:0]   ok_m, ok_1, ok_15;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_tile_resp #(.ADDR_BITS(AB), .BASE_ADDR(32'h0), .LAT(LAT_M)) u_main (
    .clock(clock), .reset(reset), .memInAddr(in_addr), .memInData(in_data),
    .memInOE(in_oe), .memInWR(in_wr), .memInOp(in_op),
    .memOutData(d_m), .memOutOK(ok_m));

  mem_tile_resp #(.ADDR_BITS(AB), .BASE_ADDR(32'h0), .LAT(1)) u_lat1 (
    .clock(clock), .reset(reset), .memInAddr(in_addr), .memInData(in_data),
    .memInOE(in_oe), .memInWR(in_wr), .memInOp(in_op),
    .memOutData(d_1), .memOutOK(ok_1));

  mem_tile_resp #(.ADDR_BITS(AB), .BASE_ADDR(32'h0), .LAT(15)) u_lat15 (
    .clock(clock), .reset(reset), .memInAddr(in_addr), .memInData(in_data),
    .memInOE(in_oe), .memInWR(in_wr), .memInOp(in_op),
    .memOutData(d_15), .memOutOK(ok_15));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- timeline model of the main instance ----------------
  int           now = 0, free_at = 0, ok_at = -1, fault_at = -1;
  logic [31:0]  p_addr;
  logic [127:0] p_data;
  logic         p_oe, p_wr, p_tile;
  logic [1:0]   exp_ok = UMEM_OK_READY;
  logic [127:0] exp_data = '0;
  bit           exp_known = 1'b1;
  bit [31:0]    mmem [int];

  function automatic bit is_illegal(input logic [31:0] a, input logic oe, input logic wr,
                                    input logic [4:0] op);
    return !(op == 5'd1 || op == 5'd2) || (oe && wr) || (longint'(a) >= RAM_BYTES);
  endfunction

  task automatic model_commit();
    int base;
    int lane;
    base = int'(p_addr >> 4) * 4;
    lane = int'(p_addr[3:2]);
    if (p_wr) begin
      if (p_tile) for (int b = 0; b < 4; b++) mmem[base + b] = p_data[b*32 +: 32];
      else        mmem[base + lane] = p_data[31:0];
    end
    if (p_oe) begin
      exp_known = 1'b1;
      exp_data  = '0;
      if (p_tile) begin
        for (int b = 0; b < 4; b++) begin
          if (mmem.exists(base + b)) exp_data[b*32 +: 32] = mmem[base + b];
          else exp_known = 1'b0;
        end
      end else begin
        if (mmem.exists(base + lane)) exp_data[31:0] = mmem[base + lane];
        else exp_known = 1'b0;
      end
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      now = 0; free_at = 0; ok_at = -1; fault_at = -1;
      exp_ok = UMEM_OK_READY; exp_data = '0; exp_known = 1'b1;
    end else begin
      if (now >= free_at && (in_oe || in_wr)) begin
        if (is_illegal(in_addr, in_oe, in_wr, in_op)) begin
          fault_at = now + 1;
          free_at  = now + 2;
        end else begin
          ok_at   = now + LAT_M + 1;
          free_at = now + LAT_M + 2;
          p_addr = in_addr; p_data = in_data; p_oe = in_oe; p_wr = in_wr;
          p_tile = (in_op == 5'd1);
        end
      end
      now++;
      if (now == fault_at)   exp_ok = UMEM_OK_FAULT;
      else if (now == ok_at) begin exp_ok = UMEM_OK_OK; model_commit(); end
      else if (now < ok_at)  exp_ok = UMEM_OK_HOLD;
      else                   exp_ok = UMEM_OK_READY;
    end
  end

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clock) begin
    check("status", 128'(ok_m), 128'(exp_ok));
    if (exp_ok == UMEM_OK_OK && exp_known) check("load_data", d_m, exp_data);
  end

  // ---------------- directed stimulus ----------------
  // One-cycle request, then wait (bounded) for OK/FAULT on the main instance.
  task automatic txn(input logic [31:0] a, input logic [127:0] d, input logic oe,
                     input logic wr, input logic [4:0] op,
                     output logic [1:0] fin, output int at, output int holds,
                     output logic [127:0] rd);
    @(negedge clock);
    in_addr = a; in_data = d; in_oe = oe; in_wr = wr; in_op = op;
    @(negedge clock);
    in_oe = 1'b0; in_wr = 1'b0;
    fin = UMEM_OK_READY; at = 0; holds = 0; rd = '0;
    for (int i = 1; i <= 40; i++) begin
      if (ok_m == UMEM_OK_HOLD) holds++;
      else if (ok_m == UMEM_OK_OK || ok_m == UMEM_OK_FAULT) begin
        fin = ok_m; at = i; rd = d_m;
        break;
      end
      @(negedge clock);
    end
    if (at == 0) begin
      checks++; errors++;
      $display("FAIL txn_timeout: got no response expected OK or FAULT");
    end
  endtask

  // Request seen by all instances; records HOLD count and OK timing of the side ones.
  task automatic side_txn(input logic [31:0] a, input logic [127:0] d, input logic oe,
                          input logic wr, output int h1, output int o1, output logic [127:0] r1,
                          output int h15, output int o15, output logic [127:0] r15);
    @(negedge clock);
    in_addr = a; in_data = d; in_oe = oe; in_wr = wr; in_op = 5'd2;
    @(negedge clock);
    in_oe = 1'b0; in_wr = 1'b0;
    h1 = 0; o1 = 0; h15 = 0; o15 = 0; r1 = '0; r15 = '0;
    for (int i = 1; i <= 20; i++) begin
      if (ok_1 == UMEM_OK_HOLD) h1++;
      if (ok_1 == UMEM_OK_OK && o1 == 0) begin o1 = i; r1 = d_1; end
      if (ok_15 == UMEM_OK_HOLD) h15++;
      if (ok_15 == UMEM_OK_OK && o15 == 0) begin o15 = i; r15 = d_15; end
      @(negedge clock);
    end
  endtask

  initial begin
    logic [1:0]   fin;
    int           at, holds;
    logic [127:0] rd;
    int           okc [4];
    logic [127:0] okd [4];
    int           n, cyc;
    int           h1, o1, h15, o15;
    logic [127:0] r1, r15;

    // Reset values.
    repeat (3) @(negedge clock);
    check("reset_status", 128'(ok_m), 128'(UMEM_OK_READY));
    check("reset_data", d_m, 128'h0);
    check("reset_status_lat1", 128'(ok_1), 128'(UMEM_OK_READY));
    check("reset_status_lat15", 128'(ok_15), 128'(UMEM_OK_READY));
    reset = 1'b1;

    // Tile 2 background, then DWORD store/load in lane B.
    txn(32'h20, 128'h33333333_22222222_11111111_00000000, 1'b0, 1'b1, 5'd1, fin, at, holds, rd);
    check("tile2_store_ok", 128'(fin), 128'(UMEM_OK_OK));
    txn(32'h24, 128'h12345678, 1'b0, 1'b1, 5'd2, fin, at, holds, rd);
    check_int("dw_store_ok_cycle", at, 3);
    txn(32'h24, 128'h0, 1'b1, 1'b0, 5'd2, fin, at, holds, rd);
    check_int("dw_load_ok_cycle", at, 3);
    check_int("dw_load_holds", holds, 2);
    check("dw_load_data", rd, 128'h12345678);
    txn(32'h20, 128'h0, 1'b1, 1'b0, 5'd1, fin, at, holds, rd);
    check("tile2_other_lanes", rd, 128'h33333333_22222222_12345678_00000000);

    // Tile store at 0x100, offset-insensitive tile load, lane D DWORD load.
    txn(32'h100, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b0, 1'b1, 5'd1, fin, at, holds, rd);
    txn(32'h108, 128'h0, 1'b1, 1'b0, 5'd1, fin, at, holds, rd);
    check("tile_load_0x108", rd, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    txn(32'h10C, 128'h0, 1'b1, 1'b0, 5'd2, fin, at, holds, rd);
    check("dw_load_0x10c", rd, 128'hDDDDDDDD);

    // Back-to-back DWORD loads with OE held, address advanced on each OK.
    txn(32'h40, 128'h4C4C4C4C_48484848_44444444_40404040, 1'b0, 1'b1, 5'd1, fin, at, holds, rd);
    @(negedge clock);
    in_addr = 32'h40; in_oe = 1'b1; in_wr = 1'b0; in_op = 5'd2;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (ok_m == UMEM_OK_OK) begin
        okc[n] = cyc; okd[n] = d_m; n++;
        in_addr = 32'h40 + 32'(4 * n);
        if (n == 4) in_oe = 1'b0;
      end
    end
    in_oe = 1'b0;
    check_int("b2b_count", n, 4);
    if (n == 4) begin
      check_int("b2b_first", okc[0], 3);
      for (int k = 1; k < 4; k++) check_int("b2b_gap", okc[k] - okc[k-1], LAT_M + 2);
      check("b2b_d0", okd[0], 128'h40404040);
      check("b2b_d1", okd[1], 128'h44444444);
      check("b2b_d2", okd[2], 128'h48484848);
      check("b2b_d3", okd[3], 128'h4C4C4C4C);
    end

    // Illegal requests: one FAULT cycle, no HOLD, RAM untouched.
    txn(32'h0, 128'h00C0FFEE, 1'b0, 1'b1, 5'd2, fin, at, holds, rd);
    txn(32'h24, 128'hBAD0BAD0, 1'b0, 1'b1, 5'd3, fin, at, holds, rd);
    check("fault_op3", 128'(fin), 128'(UMEM_OK_FAULT));
    check_int("fault_op3_cycle", at, 1);
    check_int("fault_op3_holds", holds, 0);
    txn(32'h24, 128'hBAD1BAD1, 1'b1, 1'b1, 5'd2, fin, at, holds, rd);
    check("fault_rmw", 128'(fin), 128'(UMEM_OK_FAULT));
    check_int("fault_rmw_cycle", at, 1);
    txn(32'h4000, 128'hBAD2BAD2, 1'b0, 1'b1, 5'd2, fin, at, holds, rd);
    check("fault_range", 128'(fin), 128'(UMEM_OK_FAULT));
    check_int("fault_range_holds", holds, 0);
    txn(32'h24, 128'h0, 1'b1, 1'b0, 5'd2, fin, at, holds, rd);
    check("fault_readback_0x24", rd, 128'h12345678);
    txn(32'h0, 128'h0, 1'b1, 1'b0, 5'd2, fin, at, holds, rd);
    check("fault_readback_0x0", rd, 128'h00C0FFEE);

    // Store aborted by reset during its first HOLD cycle.
    @(negedge clock);
    in_addr = 32'h24; in_data = 128'hDEADBEEF; in_wr = 1'b1; in_op = 5'd2;
    @(negedge clock);
    in_wr = 1'b0;
    check("abort_hold", 128'(ok_m), 128'(UMEM_OK_HOLD));
    #2 reset = 1'b0;
    #1 check("abort_async_ready", 128'(ok_m), 128'(UMEM_OK_READY));
    @(negedge clock);
    reset = 1'b1;
    txn(32'h24, 128'h0, 1'b1, 1'b0, 5'd2, fin, at, holds, rd);
    check("abort_old_data", rd, 128'h12345678);

    // HOLD length on the LAT=1 / LAT=15 builds, request withdrawn mid-HOLD.
    repeat (20) @(negedge clock);
    side_txn(32'h28, 128'hCAFEF00D, 1'b0, 1'b1, h1, o1, r1, h15, o15, r15);
    check_int("lat1_holds", h1, 1);
    check_int("lat1_ok_cycle", o1, 2);
    check_int("lat15_holds", h15, 15);
    check_int("lat15_ok_cycle", o15, 16);
    side_txn(32'h28, 128'h0, 1'b1, 1'b0, h1, o1, r1, h15, o15, r15);
    check("lat1_load", r1, 128'hCAFEF00D);
    check("lat15_load", r15, 128'hCAFEF00D);
    check_int("lat15_load_holds", h15, 15);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
